// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through its en/busy handshake
// Ports: clk/reset (async, active-high); wr_en/wr_data push a byte; flush empties
// the queue; clear_overflow clears the sticky drop flag; full/empty/level/overflow
// report status; tx_en/tx_data issue one byte to the transmitter; tx_busy is its busy.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    flush,
  input  logic                    clear_overflow,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  input  logic                    tx_busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                  r_state, w_next;
  logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [AW:0]             r_level;
  logic                    r_overflow, r_tx_en;
  logic [PAYLOAD_BITS-1:0] r_tx_data;
  logic                    w_full, w_empty, w_push, w_drop, w_pop;
  assign w_full   = r_level == (AW+1)'(DEPTH);
  assign w_empty  = r_level == '0;
  assign w_push   = wr_en && !w_full && !flush;
  assign w_drop   = wr_en && w_full && !flush;
  assign w_pop    = r_state == IDLE && !w_empty && !tx_busy && !flush;
  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign tx_en    = r_tx_en;
  assign tx_data  = r_tx_data;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_tx_en    <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_wr_ptr   <= flush ? '0 : r_wr_ptr + AW'(w_push);
      r_rd_ptr   <= flush ? '0 : r_rd_ptr + AW'(w_pop);
      r_level    <= flush ? '0 : r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_overflow <= w_drop ? 1'b1 : clear_overflow ? 1'b0 : r_overflow;
      r_tx_en    <= w_pop;
      r_tx_data  <= w_pop ? r_mem[r_rd_ptr] : r_tx_data;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  // WAIT_BUSY covers the cycle before the transmitter's busy becomes visible
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && w_pop)         ? WAIT_BUSY :
             (r_state == WAIT_BUSY && tx_busy)  ? WAIT_DONE :
             (r_state == WAIT_DONE && !tx_busy) ? IDLE      : r_state;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  logic       clk = 0, reset = 1, wr_en = 0, flush = 0, clear_overflow = 0, stall = 0;
  logic [7:0] wr_data = 0, tx_data;
  logic       full, empty, overflow, tx_en, tx_busy;
  logic [4:0] level;
  int         checks = 0, failures = 0, viol = 0;
  logic [7:0] issued[$], rx_q[$];
  logic       m_busy = 0, m_line, prev_en = 0;
  logic [9:0] m_sh = '1;
  int         m_idx = 0, rx_cnt = 0;
  logic [7:0] rx_b = 0;

  uart_tx_fifo #(.DEPTH(16), .PAYLOAD_BITS(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clear_overflow(clear_overflow), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy));

  always #5 clk = ~clk;

  // Transmitter model: samples en only when idle, busy rises on that edge, 10-bit frame
  assign tx_busy = m_busy | stall;
  assign m_line  = m_busy ? m_sh[m_idx] : 1'b1;
  always @(posedge clk) begin
    if (!m_busy) begin
      if (tx_en && !stall) begin
        m_busy <= 1;
        m_sh   <= {1'b1, tx_data, 1'b0};
        m_idx  <= 0;
      end
    end else if (m_idx == 9) m_busy <= 0;
    else m_idx <= m_idx + 1;
    if (tx_en && tx_busy) viol++;
    if (tx_en && prev_en) viol++;
    prev_en <= tx_en;
  end

  // Line receiver and issue monitor
  always @(negedge clk) begin
    if (tx_en) issued.push_back(tx_data);
    if (rx_cnt == 0) begin
      if (m_line == 0) rx_cnt = 1;
    end else if (rx_cnt <= 8) begin
      rx_b[rx_cnt-1] = m_line;
      rx_cnt++;
    end else begin
      rx_q.push_back(rx_b);
      rx_cnt = 0;
    end
  end

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({empty, full, level, overflow, tx_en, tx_data} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_values got e=%b f=%b l=%0d o=%b en=%b d=%h", empty, full, level, overflow, tx_en, tx_data);
    end
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({empty, level, tx_en, overflow} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL idle_cycle_%0d got e=%b l=%0d en=%b o=%b want 1 0 0 0", i, empty, level, tx_en, overflow);
      end
    end
  endtask

  task automatic test_single;
    issued.delete(); rx_q.delete();
    @(negedge clk); wr_en = 1; wr_data = 8'hA5;
    @(negedge clk); wr_en = 0;
    checks++;
    if (tx_en !== 1'b0) begin failures++; $display("FAIL single_early_en got %b want 0", tx_en); end
    @(negedge clk);
    checks++;
    if ({tx_en, tx_data, empty} !== {1'b1, 8'hA5, 1'b1}) begin
      failures++;
      $display("FAIL single_issue got en=%b d=%h e=%b want 1 a5 1", tx_en, tx_data, empty);
    end
    @(negedge clk);
    checks++;
    if (tx_en !== 1'b0) begin failures++; $display("FAIL single_pulse got en=%b want 0", tx_en); end
    repeat (15) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      failures++;
      $display("FAIL single_line got n=%0d b0=%h want 1 a5", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    issued.delete(); rx_q.delete(); viol = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); wr_en = 1; wr_data = 8'(i);
    end
    @(negedge clk); wr_en = 0;
    n = 0;
    while (rx_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (rx_q.size() != 3) begin
      failures++;
      $display("FAIL b2b_timeout got %0d frames want 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i + 1) || issued[i] !== 8'(i + 1)) begin
          failures++;
          $display("FAIL b2b_order_%0d got line=%h issued=%h want %h", i, rx_q[i], issued[i], 8'(i + 1));
        end
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (viol != 0 || issued.size() != 3) begin
      failures++;
      $display("FAIL b2b_handshake got viol=%0d issues=%0d want 0 3", viol, issued.size());
    end
  endtask

  task automatic test_overflow;
    issued.delete();
    @(negedge clk); stall = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); wr_en = 1; wr_data = 8'(8'h40 + i);
    end
    @(negedge clk); wr_en = 0;
    checks++;
    if ({full, level, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      failures++;
      $display("FAIL fill_16 got f=%b l=%0d o=%b want 1 16 0", full, level, overflow);
    end
    wr_en = 1; wr_data = 8'hEE;
    @(negedge clk); wr_en = 0;
    checks++;
    if ({overflow, level} !== {1'b1, 5'd16}) begin
      failures++;
      $display("FAIL drop_17 got o=%b l=%0d want 1 16", overflow, level);
    end
    clear_overflow = 1;
    @(negedge clk); clear_overflow = 0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL clear_ovf got %b want 0", overflow); end
    wr_en = 1; clear_overflow = 1;
    @(negedge clk); wr_en = 0; clear_overflow = 0;
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL set_wins got %b want 1", overflow); end
    flush = 1;
    @(negedge clk); flush = 0;
    checks++;
    if ({level, empty, full} !== {5'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL flush_full got l=%0d e=%b f=%b want 0 1 0", level, empty, full);
    end
    clear_overflow = 1;
    @(negedge clk); clear_overflow = 0; stall = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (issued.size() != 0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL stall_issue got issues=%0d o=%b want 0 0", issued.size(), overflow);
    end
  endtask

  task automatic test_flush;
    issued.delete(); rx_q.delete();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); wr_en = 1; wr_data = 8'(8'h11 * i);
    end
    @(negedge clk); wr_en = 0;
    flush = 1; wr_en = 1; wr_data = 8'h99;
    @(negedge clk); flush = 0; wr_en = 0;
    checks++;
    if ({level, empty} !== {5'd0, 1'b1}) begin
      failures++;
      $display("FAIL flush_level got l=%0d e=%b want 0 1", level, empty);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (issued.size() != 1 || issued[0] !== 8'h11 || rx_q.size() != 1 || rx_q[0] !== 8'h11) begin
      failures++;
      $display("FAIL flush_issue got issues=%0d frames=%0d want only 11", issued.size(), rx_q.size());
    end
    checks++;
    if (level !== 5'd0) begin failures++; $display("FAIL flush_wr_ignored got l=%0d want 0", level); end
  endtask

  task automatic test_reset_midframe;
    int n;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); wr_en = 1; wr_data = 8'(8'h21 + i);
    end
    @(negedge clk); wr_en = 0;
    checks++;
    if (level !== 5'd7) begin failures++; $display("FAIL pre_reset_level got %0d want 7", level); end
    reset = 1;
    #1;
    checks++;
    if ({tx_en, level, empty, full, overflow, tx_data} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL async_reset got en=%b l=%0d e=%b f=%b o=%b d=%h", tx_en, level, empty, full, overflow, tx_data);
    end
    @(negedge clk); reset = 0;
    issued.delete();
    @(negedge clk); wr_en = 1; wr_data = 8'h3C;
    @(negedge clk); wr_en = 0;
    n = 0;
    while (issued.size() == 0 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (issued.size() == 0 || issued[0] !== 8'h3C) begin
      failures++;
      $display("FAIL post_reset_first got n=%0d b0=%h want 3c", issued.size(), issued.size() > 0 ? issued[0] : 8'hxx);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (issued.size() != 1 || level !== 5'd0) begin
      failures++;
      $display("FAIL post_reset_only got issues=%0d l=%0d want 1 0", issued.size(), level);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_flush;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
